// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package ifetch_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      EXT_WAIT = 1'b1
   } state_e;

   localparam logic [31:0] NOP_INS = 32'h0000_0013;

   // True when a byte address lies inside the local IMEM window [0, depth*4).
   function automatic logic in_local_window(input logic [63:0] addr, input int unsigned depth);
      return addr < (64'(depth) << 2);
   endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: branch/hazard control in, decode outputs, external instruction port.
interface ifetch_if #(
   parameter int unsigned XLEN = 32
);
   logic            stall;
   logic            br_en;
   logic [XLEN-1:0] br_addr;
   logic [XLEN-1:0] PC;
   logic [31:0]     ins_out;
   logic            ins_valid;
   logic            exIns_ren;
   logic [XLEN-1:0] exIns_addr;
   logic            exIns_valid;
   logic [31:0]     exIns_in;
   logic            ext_err;

   modport master (
      input  stall, br_en, br_addr, exIns_valid, exIns_in,
      output PC, ins_out, ins_valid, exIns_ren, exIns_addr, ext_err
   );

   modport slave (
      output stall, br_en, br_addr, exIns_valid, exIns_in,
      input  PC, ins_out, ins_valid, exIns_ren, exIns_addr, ext_err
   );
endinterface

// File: rtl/ifetch_imem.sv
// Local instruction memory: DEPTH x 32, one-cycle synchronous read, read data held when idle.
module ifetch_imem #(
   parameter int unsigned DEPTH = 512,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata
);
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads local IMEM or an external port with timeout.
// Optional performance counters are enabled by defining IFETCH_PERF_CNT_EN.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     IMEM_DEPTH  = 512,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int unsigned     EXT_TIMEOUT = 15,
   parameter logic [31:0]     NOP_INS     = ifetch_pkg::NOP_INS
) (
   input  logic     clk,
   input  logic     nrst,
   ifetch_if.master io
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_ext_cnt
`endif
);
   localparam int unsigned AW = $clog2(IMEM_DEPTH);
   localparam int unsigned TW = $clog2(EXT_TIMEOUT + 1);

   state_e          state_q, state_d;
   logic [XLEN-1:0] fa_q, fa_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     ins_q, ins_d;
   logic            valid_q, valid_d;
   logic            src_local_q, src_local_d;
   logic            ren_q, ren_d;
   logic [XLEN-1:0] eaddr_q, eaddr_d;
   logic            err_q, err_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            buf_valid_q, buf_valid_d;
   logic [31:0]     buf_data_q, buf_data_d;
   logic            ram_re;
   logic [31:0]     ram_rdata;
   logic [31:0]     ext_data;
   logic            ext_done;

   ifetch_imem #(.DEPTH(IMEM_DEPTH)) u_imem (
      .clk   (clk),
      .re    (ram_re),
      .raddr (fa_q[AW+1:2]),
      .rdata (ram_rdata),
      .we    (1'b0),
      .waddr ('0),
      .wdata ('0)
   );

   assign ext_data = buf_valid_q ? buf_data_q : io.exIns_in;

   // Next-state logic; branch overrides everything, stall freezes the decode-facing view.
   always_comb begin
      state_d     = state_q;
      fa_d        = fa_q;
      pc_d        = pc_q;
      ins_d       = ins_q;
      valid_d     = valid_q;
      src_local_d = src_local_q;
      ren_d       = ren_q;
      eaddr_d     = eaddr_q;
      err_d       = 1'b0;
      tmo_d       = tmo_q;
      buf_valid_d = buf_valid_q;
      buf_data_d  = buf_data_q;
      ram_re      = 1'b0;
      ext_done    = 1'b0;

      if (io.br_en) begin
         state_d     = RUN;
         fa_d        = io.br_addr & ~XLEN'(3);
         ins_d       = NOP_INS;
         valid_d     = 1'b0;
         src_local_d = 1'b0;
         ren_d       = 1'b0;
         tmo_d       = '0;
         buf_valid_d = 1'b0;
      end else if (state_q == RUN) begin
         if (!io.stall) begin
            if (in_local_window(64'(fa_q), IMEM_DEPTH)) begin
               ram_re      = 1'b1;
               pc_d        = fa_q;
               valid_d     = 1'b1;
               src_local_d = 1'b1;
               fa_d        = fa_q + XLEN'(4);
            end else begin
               state_d     = EXT_WAIT;
               ren_d       = 1'b1;
               eaddr_d     = fa_q;
               ins_d       = NOP_INS;
               valid_d     = 1'b0;
               src_local_d = 1'b0;
               tmo_d       = '0;
            end
         end
      end else begin
         if (buf_valid_q || io.exIns_valid) begin
            if (io.stall) begin
               // Park the arrived word until decode can take it.
               buf_valid_d = 1'b1;
               buf_data_d  = ext_data;
               ren_d       = 1'b0;
            end else begin
               state_d     = RUN;
               ins_d       = ext_data;
               pc_d        = fa_q;
               valid_d     = 1'b1;
               src_local_d = 1'b0;
               fa_d        = fa_q + XLEN'(4);
               ren_d       = 1'b0;
               buf_valid_d = 1'b0;
               tmo_d       = '0;
               ext_done    = 1'b1;
            end
         end else if (tmo_q == TW'(EXT_TIMEOUT - 1)) begin
            // Give up on this attempt; RUN re-requests the same FA.
            state_d = RUN;
            err_d   = 1'b1;
            ren_d   = 1'b0;
            ins_d   = NOP_INS;
            valid_d = 1'b0;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q     <= RUN;
         fa_q        <= RESET_PC;
         pc_q        <= RESET_PC;
         ins_q       <= NOP_INS;
         valid_q     <= 1'b0;
         src_local_q <= 1'b0;
         ren_q       <= 1'b0;
         eaddr_q     <= '0;
         err_q       <= 1'b0;
         tmo_q       <= '0;
         buf_valid_q <= 1'b0;
         buf_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         fa_q        <= fa_d;
         pc_q        <= pc_d;
         ins_q       <= ins_d;
         valid_q     <= valid_d;
         src_local_q <= src_local_d;
         ren_q       <= ren_d;
         eaddr_q     <= eaddr_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
         buf_valid_q <= buf_valid_d;
         buf_data_q  <= buf_data_d;
      end
   end

   assign io.PC         = pc_q;
   assign io.ins_out    = src_local_q ? ram_rdata : ins_q;
   assign io.ins_valid  = valid_q;
   assign io.exIns_ren  = ren_q;
   assign io.exIns_addr = eaddr_q;
   assign io.ext_err    = err_q;

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_fetch_d;
   logic [31:0] perf_ext_q, perf_ext_d;

   always_comb begin
      perf_fetch_d = perf_fetch_q + 32'(valid_q && !io.stall);
      perf_ext_d   = perf_ext_q + 32'(ext_done);
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         perf_fetch_q <= '0;
         perf_ext_q   <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_ext_q   <= perf_ext_d;
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_ext_cnt   = perf_ext_q;
`else
   logic unused_ext_done;
   assign unused_ext_done = ext_done;
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed table-driven bench for ifetch_unit plus timeout and reset-mid-wait sequences.
module tb_ifetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int NV = 26;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   ifetch_if #(.XLEN(32)) bus ();

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_ext_cnt;
`endif

   ifetch_unit #(.XLEN(32), .IMEM_DEPTH(512), .RESET_PC(32'h0), .EXT_TIMEOUT(15)) dut (
      .clk  (clk),
      .nrst (nrst),
      .io   (bus)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_ext_cnt   (perf_ext_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] br_addr;
      logic        exv;
      logic [31:0] exd;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] eins;
      logic        eren;
      logic [31:0] eaddr;
   } vec_t;

   vec_t vecs [NV];

   function automatic vec_t mk(input logic st, input logic br, input logic [31:0] ba,
                               input logic exv, input logic [31:0] exd,
                               input logic ev, input logic [31:0] epc, input logic [31:0] eins,
                               input logic eren, input logic [31:0] eaddr);
      vec_t v;
      v.stall = st; v.br = br; v.br_addr = ba; v.exv = exv; v.exd = exd;
      v.ev = ev; v.epc = epc; v.eins = eins; v.eren = eren; v.eaddr = eaddr;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic br, input logic [31:0] ba,
                        input logic exv, input logic [31:0] exd);
      bus.stall = st; bus.br_en = br; bus.br_addr = ba;
      bus.exIns_valid = exv; bus.exIns_in = exd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int err_cnt;
      int err_first;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 512; i++) dut.u_imem.mem[i] = 32'h5a01_0000 + 32'(i * 4);

      //            st br  br_addr       exv exd            ev epc           eins           ren addr
      vecs[0]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0,        32'h5a010000, 0, 32'h0);
      vecs[1]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h4,        32'h5a010004, 0, 32'h0);
      vecs[2]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h8,        32'h5a010008, 0, 32'h0);
      vecs[3]  = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h8,        32'h5a010008, 0, 32'h0);
      vecs[4]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'hC,        32'h5a01000C, 0, 32'h0);
      vecs[5]  = mk(1, 1, 32'h7FB,       0, 32'h0,         0, 32'h0,        NOP,          0, 32'h0);
      vecs[6]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h7F8,      32'h5a0107F8, 0, 32'h0);
      vecs[7]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h7FC,      32'h5a0107FC, 0, 32'h0);
      vecs[8]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0,        NOP,          1, 32'h800);
      vecs[9]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0,        NOP,          1, 32'h800);
      vecs[10] = mk(0, 0, 32'h0,         1, 32'h5a5a0800,  1, 32'h800,      32'h5a5a0800, 0, 32'h0);
      vecs[11] = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0,        NOP,          1, 32'h804);
      vecs[12] = mk(1, 0, 32'h0,         1, 32'h5a5a0804,  0, 32'h0,        NOP,          0, 32'h0);
      vecs[13] = mk(1, 0, 32'h0,         0, 32'h0,         0, 32'h0,        NOP,          0, 32'h0);
      vecs[14] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h804,      32'h5a5a0804, 0, 32'h0);
      vecs[15] = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h804,      32'h5a5a0804, 0, 32'h0);
      vecs[16] = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0,        NOP,          1, 32'h808);
      vecs[17] = mk(0, 1, 32'h0,         0, 32'h0,         0, 32'h0,        NOP,          0, 32'h0);
      vecs[18] = mk(0, 0, 32'h0,         1, 32'hdeadbeef,  1, 32'h0,        32'h5a010000, 0, 32'h0);
      vecs[19] = mk(0, 1, 32'hFFFFFFFC,  0, 32'h0,         0, 32'h0,        NOP,          0, 32'h0);
      vecs[20] = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0,        NOP,          1, 32'hFFFFFFFC);
      vecs[21] = mk(0, 0, 32'h0,         1, 32'h5a59fffc,  1, 32'hFFFFFFFC, 32'h5a59fffc, 0, 32'h0);
      vecs[22] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0,        32'h5a010000, 0, 32'h0);
      vecs[23] = mk(0, 1, 32'h7FC,       0, 32'h0,         0, 32'h0,        NOP,          0, 32'h0);
      vecs[24] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h7FC,      32'h5a0107FC, 0, 32'h0);
      vecs[25] = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0,        NOP,          1, 32'h800);

      tick();
      tick();
      check("rst_pc",    0, bus.PC, 32'h0);
      check("rst_ins",   0, bus.ins_out, NOP);
      check("rst_valid", 0, 32'(bus.ins_valid), 32'h0);
      check("rst_ren",   0, 32'(bus.exIns_ren), 32'h0);
      check("rst_addr",  0, bus.exIns_addr, 32'h0);
      check("rst_err",   0, 32'(bus.ext_err), 32'h0);

      nrst = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].stall, vecs[i].br, vecs[i].br_addr, vecs[i].exv, vecs[i].exd);
         tick();
         check("valid", i, 32'(bus.ins_valid), 32'(vecs[i].ev));
         check("ins",   i, bus.ins_out, vecs[i].eins);
         check("ren",   i, 32'(bus.exIns_ren), 32'(vecs[i].eren));
         check("err",   i, 32'(bus.ext_err), 32'h0);
         if (vecs[i].ev)   check("pc",   i, bus.PC, vecs[i].epc);
         if (vecs[i].eren) check("addr", i, bus.exIns_addr, vecs[i].eaddr);
      end

      // External port never answers: one error pulse after 15 wait cycles, then re-request.
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      err_cnt = 0;
      err_first = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.ext_err) begin
            err_cnt++;
            if (err_first == 0) err_first = i;
         end
         if (i == 15) begin
            check("tmo_ren_drop", i, 32'(bus.exIns_ren), 32'h0);
            check("tmo_valid",    i, 32'(bus.ins_valid), 32'h0);
            check("tmo_ins",      i, bus.ins_out, NOP);
         end
         if (i == 16) begin
            check("tmo_reissue_ren",  i, 32'(bus.exIns_ren), 32'h1);
            check("tmo_reissue_addr", i, bus.exIns_addr, 32'h800);
         end
      end
      check("tmo_err_cycle", 0, 32'(err_first), 32'd15);
      check("tmo_err_count", 0, 32'(err_cnt), 32'd1);

      // Reset while a request is outstanding.
      check("pre_rst_ren", 0, 32'(bus.exIns_ren), 32'h1);
      nrst = 1'b0;
      tick();
      check("mid_rst_ren",   0, 32'(bus.exIns_ren), 32'h0);
      check("mid_rst_addr",  0, bus.exIns_addr, 32'h0);
      check("mid_rst_valid", 0, 32'(bus.ins_valid), 32'h0);
      check("mid_rst_ins",   0, bus.ins_out, NOP);
      nrst = 1'b1;
      tick();
      check("post_rst_valid", 0, 32'(bus.ins_valid), 32'h1);
      check("post_rst_pc",    0, bus.PC, 32'h0);
      check("post_rst_ins",   0, bus.ins_out, 32'h5a010000);
      tick();
      check("post_rst_pc",    1, bus.PC, 32'h4);
      check("post_rst_ins",   1, bus.ins_out, 32'h5a010004);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Parametrised next-generation instruction fetch stage. Owns the PC and a local synchronous IMEM. Fetches from an external instruction port via a ren/valid handshake when the PC falls outside the local IMEM.
- Adds over the previous fetch block: parametrised depth, reset vector and XLEN; explicit `ins_valid`; branch-during-external-wait cancellation; external timeout with error flag.
- Sits between the branch/hazard unit and the decode stage.

Parameters:
- XLEN, 32, instruction/address width.
- IMEM_DEPTH, 512, local IMEM words (power of 2); local window is [0, IMEM_DEPTH*4).
- RESET_PC, 0, PC after reset.
- EXT_TIMEOUT, 15, max cycles waiting on `exIns_valid` before error.
- NOP_INS, 32'h00000013, bubble instruction.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  synchronous active-low reset.
- stall  in  1  decode hold request.
- br_en  in  1  branch redirect strobe.
- br_addr  in  XLEN  redirect target; bits [1:0] forced to 0.
- PC  out  XLEN  address of instruction on `ins_out`.
- ins_out  out  32  fetched instruction, NOP_INS when invalid.
- ins_valid  out  1  `ins_out`/`PC` hold a real instruction.
- exIns_ren  out  1  external read request.
- exIns_addr  out  XLEN  external read address.
- exIns_valid  in  1  external data valid.
- exIns_in  in  32  external instruction data.
- ext_err  out  1  one-cycle pulse on external timeout.

Behaviour:
- Reset: one clock and reset domain; reset is synchronous and active-low. Sampled at posedge while `nrst`=0.
  - `PC`=RESET_PC, `ins_out`=NOP_INS, `ins_valid`=0, `exIns_ren`=0, `exIns_addr`=0, `ext_err`=0, state=RUN, timeout counter=0.
- Fetch address register FA holds the next address to fetch.
- Local IMEM: one-cycle synchronous read.
  - FA presented at edge N gives data at edge N+1, with `PC`=FA, `ins_valid`=1.
  - Sequential fetch sustains 1 instruction/cycle.
  - First valid instruction appears 1 cycle after reset deassert.
- States: RUN, EXT_WAIT.
  - RUN, FA in local window: read IMEM; FA<=FA+4.
  - RUN, FA outside local window: go to EXT_WAIT; `exIns_ren`=1, `exIns_addr`=FA; `ins_valid`=0.
  - EXT_WAIT: `exIns_ren` and `exIns_addr` held stable until `exIns_valid` is sampled 1. Then `ins_out`=`exIns_in`, `PC`=FA, `ins_valid`=1, `exIns_ren`=0, FA<=FA+4, return to RUN.
  - EXT_WAIT: counter increments each cycle. When it reaches EXT_TIMEOUT: `ext_err`=1 for one cycle, `ins_out`=NOP_INS, `ins_valid`=0, `exIns_ren` dropped, then re-request the same FA.
- Stall (`stall`=1, `br_en`=0):
  - `PC`, `ins_out`, `ins_valid` and FA held.
  - In EXT_WAIT the request continues. Data that arrives is buffered internally (1 entry) and presented on the first non-stalled cycle.
- Branch (`br_en`=1, highest priority, overrides `stall`):
  - Next cycle: `ins_valid`=0, `ins_out`=NOP_INS, FA<=`br_addr`&~3.
  - Any outstanding external request is cancelled (`exIns_ren`=0 next cycle), and late `exIns_valid` is ignored.
  - Local target: valid on the second cycle after `br_en`.
- Wrap-around: FA+4 wraps modulo 2^XLEN.
  - Crossing the IMEM_DEPTH*4 boundary moves to external fetch with no extra bubble beyond the handshake.
- Reset mid-EXT_WAIT: request dropped immediately at that edge.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- When defined, adds outputs:
  - `perf_fetch_cnt` (32): counts cycles with `ins_valid`=1 and `stall`=0.
  - `perf_ext_cnt` (32): counts completed external fetches.
  - Both clear on reset and wrap at 2^32.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package `ifetch_pkg`:
  - state enum {RUN, EXT_WAIT};
  - NOP_INS constant;
  - local-window compare helper function.
- One sub-module: `ifetch_imem`, a parametrised depth × 32 synchronous-read RAM with preload access for benches.

Test Plan:
- Preload IMEM[i]=32'h5a010000+4i, RESET_PC=0, release `nrst` → `ins_valid` rises 1 cycle later with `PC`=0, `ins_out`=5a010000; next cycle `PC`=4, `ins_out`=5a010004.
- Stall high 1 cycle at `PC`=8 → `PC`/`ins_out` held at 8/5a010008 for the stalled cycle, then `PC`=C.
- `br_en` with `br_addr`=IMEM_DEPTH*4-8 (0x7F8) → 1 bubble (`ins_valid`=0, NOP); then `PC`=7F8, then 7FC; then `exIns_ren`=1, `exIns_addr`=800.
- External responder: `exIns_valid` 2 cycles after `exIns_ren`, data=32'h5a5a0000+addr → `ins_out`=5a5a0800, `PC`=800, `ins_valid`=1, next request 804.
- `exIns_valid` never asserted → `ext_err` pulses exactly once after 15 wait cycles; the request is reissued to the same address.
- `br_en` to 0 during EXT_WAIT, then `exIns_valid` arrives a cycle later → data ignored; `PC`=0, `ins_out`=5a010000 on the second cycle after the branch.
